// File: rtl/aer_event_packer.sv
// rtl/aer_event_packer.sv - timestamps AER pixel events and queues them in a FIFO with drop accounting
module aer_event_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          evt_valid_i,
  input  logic [1:0]                    grp_x_i,
  input  logic [1:0]                    grp_y_i,
  input  logic [1:0]                    pix_x_i,
  input  logic [1:0]                    pix_y_i,
  input  logic                          pol_i,
  input  logic                          clr_i,
  output logic [8+TS_WIDTH:0]           evt_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic                          ovf_o,
  output logic [7:0]                    drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 9 + TS_WIDTH;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;
  logic [TS_WIDTH-1:0] r_ts;
  logic [7:0]          r_drop_cnt;
  logic                r_ovf;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [EW-1:0]       w_evt;

  assign w_evt       = {pol_i, r_ts, grp_x_i, pix_x_i, grp_y_i, pix_y_i};
  assign w_full      = (r_level == LW'(FIFO_DEPTH));
  assign evt_valid_o = (r_state != S_EMPTY);
  assign w_pop       = evt_valid_o && evt_ready_i;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign w_push      = evt_valid_i && (!w_full || w_pop);
  assign w_drop      = evt_valid_i && w_full && !w_pop;

  assign evt_o      = evt_valid_o ? r_mem[r_rptr] : '0;
  assign level_o    = r_level;
  assign ovf_o      = r_ovf;
  assign drop_cnt_o = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_evt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ts    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_state <= S_EMPTY;
    end else begin
      r_ts    <= r_ts + TS_WIDTH'(1);
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_state_nxt = S_VALID;
      S_VALID, S_STALL: begin
        if (w_pop && (r_level == LW'(1)) && !w_push) w_state_nxt = S_EMPTY;
        else if (!evt_ready_i)                       w_state_nxt = S_STALL;
        else                                         w_state_nxt = S_VALID;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // A drop in the clearing cycle counts as the first drop after the clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clr_i)                    r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (clr_i) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aer_event_packer.sv
// tb/tb_aer_event_packer.sv - self-checking bench for aer_event_packer
module tb_aer_event_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        evt_valid_i = 1'b0;
  logic [1:0]  grp_x_i = '0, grp_y_i = '0, pix_x_i = '0, pix_y_i = '0;
  logic        pol_i = 1'b0, clr_i = 1'b0, evt_ready_i = 1'b0;
  logic [24:0] evt_o;
  logic        evt_valid_o, ovf_o;
  logic [7:0]  drop_cnt_o;
  logic [3:0]  level_o;

  int checks = 0;
  int errors = 0;

  logic [24:0] m_q[$];
  int          m_ts = 0;
  int          m_drop = 0;
  bit          m_ovf = 0;

  aer_event_packer #(.FIFO_DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid_i(evt_valid_i),
    .grp_x_i(grp_x_i), .grp_y_i(grp_y_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .pol_i(pol_i), .clr_i(clr_i), .evt_o(evt_o), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [1:0] gx, px, gy, py;
    bit       pol;
    bit [7:0] exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_evt", evt_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_q.delete();
    m_ts = 0; m_drop = 0; m_ovf = 0;
  endtask

  // One clock: drive inputs, compare outputs against the queue model, advance the model.
  task automatic cycle(input bit vin, input bit [1:0] gx, input bit [1:0] px,
                       input bit [1:0] gy, input bit [1:0] py, input bit pol,
                       input bit rdy, input bit clr);
    bit pop, push, drop, full;
    logic [24:0] ev, head;
    logic [15:0] ts16;
    evt_valid_i = vin; grp_x_i = gx; pix_x_i = px; grp_y_i = gy; pix_y_i = py;
    pol_i = pol; evt_ready_i = rdy; clr_i = clr;
    head = (m_q.size() > 0) ? m_q[0] : 25'd0;
    chk("mdl_valid", evt_valid_o, m_q.size() > 0);
    chk("mdl_level", level_o, m_q.size());
    chk("mdl_evt", evt_o, head);
    chk("mdl_ovf", ovf_o, m_ovf);
    chk("mdl_drop", drop_cnt_o, m_drop);
    full = (m_q.size() == 8);
    pop  = (m_q.size() > 0) && rdy;
    push = vin && (!full || pop);
    drop = vin && full && !pop;
    ts16 = m_ts[15:0];
    ev   = {pol, ts16, gx, px, gy, py};
    @(posedge clk); #1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(ev);
    if (drop) begin
      m_ovf  = 1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf = 0; m_drop = 0;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic push_row(input int r, input bit rdy);
    bit [3:0] rr;
    rr = r[3:0];
    cycle(1, rr[3:2], rr[1:0], 0, 0, 1, rdy, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{2'd2, 2'd3, 2'd1, 2'd0, 1'b1, 8'hB4};
    vecs[1] = '{2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00};
    vecs[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b1, 8'hFF};
    vecs[3] = '{2'd1, 2'd2, 2'd0, 2'd3, 1'b0, 8'h63};
    vecs[4] = '{2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 8'h18};
    vecs[5] = '{2'd3, 2'd0, 2'd0, 2'd2, 1'b0, 8'hC2};

    // First event after reset, stamped at ts = 5
    do_reset();
    for (int i = 0; i < 5; i++) idle(1);
    cycle(1, 2'd2, 2'd3, 2'd1, 2'd0, 1, 1, 0);
    chk("first_evt", evt_o, {1'b1, 16'd5, 8'hB4});
    chk("first_valid", evt_valid_o, 1);
    idle(1);
    chk("first_one_cycle", evt_valid_o, 0);

    // Address packing table, streamed back to back
    foreach (vecs[i]) begin
      cycle(1, vecs[i].gx, vecs[i].px, vecs[i].gy, vecs[i].py, vecs[i].pol, 1, 0);
      chk("tbl_addr", evt_o[7:0], vecs[i].exp_addr);
      chk("tbl_pol", evt_o[24], vecs[i].pol);
    end
    idle(1);
    chk("tbl_drained", evt_valid_o, 0);

    // Overfill by one, then drain in order
    do_reset();
    for (int i = 1; i <= 9; i++) push_row(i, 0);
    chk("ovf_level", level_o, 8);
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_drop", drop_cnt_o, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", evt_o[7:4], i);
      idle(1);
    end
    chk("drain_empty", evt_valid_o, 0);
    chk("drain_level", level_o, 0);

    // Push and pop together while full
    do_reset();
    for (int i = 1; i <= 8; i++) push_row(i, 0);
    push_row(9, 1);
    chk("fullpp_level", level_o, 8);
    chk("fullpp_drop", drop_cnt_o, 0);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpp_order", evt_o[7:4], i);
      idle(1);
    end

    // Drop counter saturation and clear
    do_reset();
    for (int i = 1; i <= 8; i++) push_row(i, 0);
    for (int i = 0; i < 300; i++) push_row(i % 16, 0);
    chk("sat_drop", drop_cnt_o, 255);
    chk("sat_ovf", ovf_o, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_drop", drop_cnt_o, 0);
    chk("clr_ovf", ovf_o, 0);
    chk("clr_level", level_o, 8);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    chk("clrdrop_drop", drop_cnt_o, 1);
    chk("clrdrop_ovf", ovf_o, 1);

    // Timestamp wrap
    do_reset();
    evt_valid_i = 0; evt_ready_i = 1; clr_i = 0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk); #1;
      m_ts = (m_ts + 1) % 65536;
    end
    push_row(3, 1);
    chk("wrap_ffff", evt_o[23:8], 16'hFFFF);
    push_row(4, 1);
    chk("wrap_0000", evt_o[23:8], 16'h0000);
    idle(1);

    // Reset with events queued and stalled output
    do_reset();
    for (int i = 1; i <= 4; i++) push_row(i, 0);
    chk("midrst_level_pre", level_o, 4);
    do_reset();
    idle(0); idle(0); idle(0);
    chk("midrst_stale", evt_valid_o, 0);
    push_row(5, 1);
    chk("midrst_ts", evt_o[23:8], 16'd3);
    chk("midrst_row", evt_o[7:4], 5);

    // Randomized traffic against the queue model
    do_reset();
    for (int ph = 0; ph < 15; ph++) begin
      int p_v, p_r;
      p_v = $urandom_range(20, 95);
      p_r = $urandom_range(5, 95);
      for (int i = 0; i < 200; i++) begin
        bit [8:0] rb;
        rb = 9'($urandom);
        cycle($urandom_range(0, 99) < p_v, rb[1:0], rb[3:2], rb[5:4], rb[7:6], rb[8],
              $urandom_range(0, 99) < p_r, $urandom_range(0, 49) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aer_event_packer.md
AER_EVENT_PACKER -- requirements
Module: aer_event_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TS_WIDTH, default 16, timestamp counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 SHALL have port evt_valid_i  input  1  one event offered this cycle by the pixel arbitration stage.
REQ-006 SHALL have port grp_x_i  input  2  granted group row index.
REQ-007 SHALL have port grp_y_i  input  2  granted group column index.
REQ-008 SHALL have port pix_x_i  input  2  pixel row index inside the granted group.
REQ-009 SHALL have port pix_y_i  input  2  pixel column index inside the granted group.
REQ-010 SHALL have port pol_i  input  1  event polarity (1 = ON, 0 = OFF).
REQ-011 SHALL have port clr_i  input  1  synchronous clear of drop counter and overflow flag.
REQ-012 SHALL have port evt_o  output  9+TS_WIDTH  packed event {pol, ts, row[3:0], col[3:0]}.
REQ-013 SHALL have port evt_valid_o  output  1  evt_o holds a valid event.
REQ-014 SHALL have port evt_ready_i  input  1  downstream accepts evt_o this cycle.
REQ-015 SHALL have port ovf_o  output  1  sticky flag: at least one event dropped.
REQ-016 SHALL have port drop_cnt_o  output  8  count of dropped events, saturating.
REQ-017 SHALL have port level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 SHALL form row = {grp_x_i, pix_x_i} and col = {grp_y_i, pix_y_i} (16x16 pixel address).
REQ-019 SHALL run a free-running TS_WIDTH-bit timestamp counter, +1 every cycle, wrapping all-ones -> 0.
REQ-020 SHALL stamp each event with the counter value of the cycle in which evt_valid_i = 1.
REQ-021 SHALL push the event when evt_valid_i = 1 and FIFO not full, or full with a pop in the same cycle.
REQ-022 SHALL drop the event when evt_valid_i = 1, FIFO full and no pop that cycle; no FIFO state change.
REQ-023 SHALL on each drop set ovf_o = 1 and increment drop_cnt_o, saturating at 255.
REQ-024 SHALL pop when evt_valid_o = 1 and evt_ready_i = 1 (transfer); evt_o/evt_valid_o SHALL stay stable while evt_valid_o = 1 and evt_ready_i = 0.
REQ-025 SHALL present evt_o from the FIFO head: an event pushed into an empty FIFO at edge N appears with evt_valid_o = 1 after edge N (1-cycle latency).
REQ-026 SHALL support simultaneous push and pop at any occupancy; level_o unchanged in that case.
REQ-027 SHALL deliver events strictly in arrival order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL implement output state machine EMPTY (evt_valid_o = 0), VALID (head presented), STALL (VALID with evt_ready_i = 0); EMPTY->VALID on push, VALID->STALL on no ready, STALL->VALID on ready with level > 1, VALID/STALL->EMPTY on pop of last entry without simultaneous push.
REQ-029 SHALL on clr_i = 1 zero drop_cnt_o and ovf_o next edge; a drop in the same cycle wins (drop_cnt_o = 1, ovf_o = 1).
REQ-030 SHALL NOT alter FIFO contents, pointers or timestamp on clr_i.

Reset
REQ-031 SHALL on rst_n = 1 immediately force: evt_valid_o = 0, evt_o = 0, level_o = 0, ovf_o = 0, drop_cnt_o = 0, timestamp = 0, pointers = 0, FSM = EMPTY.
REQ-032 SHALL discard all queued events when reset asserts mid-operation; first post-reset event carries timestamp counted from reset release.

Verification
REQ-033 Reset release, evt_valid_i = 1 at ts = 5, grp (2,1), pix (3,0), pol 1, evt_ready_i = 1 -> next cycle evt_o = {1, 16'd5, 4'hB, 4'h4}, evt_valid_o = 1 for exactly one cycle.
REQ-034 evt_ready_i = 0, push 9 events at DEPTH 8 -> level_o = 8, 9th dropped, ovf_o = 1, drop_cnt_o = 1; then drain -> events 1..8 in order, evt_valid_o = 0 afterwards.
REQ-035 FIFO full, evt_valid_i = 1 and evt_ready_i = 1 same cycle -> no drop, level_o stays 8, new event appears last.
REQ-036 Hold full and push 300 events -> drop_cnt_o = 255 saturated; clr_i = 1 -> drop_cnt_o = 0, ovf_o = 0.
REQ-037 Run 65536 cycles, push at ts = 65535 and next cycle -> stamps 16'hFFFF then 16'h0000.
REQ-038 Assert rst_n with 4 events queued and evt_ready_i = 0 -> evt_valid_o = 0, level_o = 0 without a clock edge; no stale event after release.
